// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage access controller for the 16-bit pipeline.
//
// This block sits between the EX/MEM and MEM/WB pipeline registers. It turns a
// load/store held in EX/MEM into a req/ack handshake with a variable-latency
// data memory. While the access is in flight, it stalls the upstream pipeline.
//
// Optional feature: define MEM_TIMEOUT_EN to add the wait counter and the ERR
// state. When an access times out, it is aborted and the faulting instruction
// becomes a bubble in MEM/WB. Without the macro, ACCESS waits for mem_ack
// indefinitely, and mem_err / MEMWBclear are tied to 0.
//
// Parameters:
//   ADDR_W   data memory address width
//   DATA_W   data word width
//   TIMEOUT  ACCESS cycles without ack before abort (1..15)
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   exmem_valid       EX/MEM holds a valid instruction
//   exmem_memread     instruction is a load
//   exmem_memwrite    instruction is a store (wins over memread)
//   exmem_addr        effective address
//   exmem_wdata       store data
//   mem_req           registered request to data memory
//   mem_we            registered write enable, qualified by mem_req
//   mem_addr          registered request address
//   mem_wdata         registered store data
//   mem_ack           memory completion pulse
//   mem_rdata         read data, valid with mem_ack
//   dataMemOut        registered load result into MEM/WB
//   wr_MEMWB          MEM/WB load enable
//   MEMWBclear        MEM/WB bubble insert
//   stall             freeze PC, IF/ID, ID/EX and EX/MEM
//   mem_err           one-cycle pulse on access timeout
module mem_access_ctrl #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exmem_valid,
    input  logic              exmem_memread,
    input  logic              exmem_memwrite,
    input  logic [ADDR_W-1:0] exmem_addr,
    input  logic [DATA_W-1:0] exmem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] dataMemOut,
    output logic              wr_MEMWB,
    output logic              MEMWBclear,
    output logic              stall,
    output logic              mem_err
);

`ifdef MEM_TIMEOUT_EN
    typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;
`else
    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
`endif

    state_e state_q, state_d;
    logic   memop;
    logic   start;     // IDLE accepting a new memory op this cycle
    logic   ack_take;  // ack seen while in ACCESS
    logic   timeout;   // last allowed ACCESS cycle passed with no ack

    assign memop    = exmem_valid & (exmem_memread | exmem_memwrite);
    assign start    = (state_q == StIdle) & memop;
    assign ack_take = (state_q == StAccess) & mem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);

    logic [3:0] wait_cnt_q;

    assign timeout = (state_q == StAccess) & ~mem_ack & (wait_cnt_q == TimeoutLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
        end else if (start) begin
            wait_cnt_q <= 4'd0;
        end else if ((state_q == StAccess) && !mem_ack && !timeout) begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
        end
    end

    assign mem_err    = (state_q == StErr);
    assign MEMWBclear = (state_q == StErr);
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
    assign mem_err        = 1'b0;
    assign MEMWBclear     = 1'b0;
`endif

    // Next state and pipeline-control outputs.
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        wr_MEMWB = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Non-memory instructions flow through with no penalty.
                stall    = memop;
                wr_MEMWB = ~memop;
                if (memop) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                stall = 1'b1;
                // Ack wins over timeout in the same cycle.
                if (mem_ack) begin
                    state_d = StDone;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    state_d = StErr;
                end
`endif
            end
            StDone: begin
                wr_MEMWB = 1'b1;
                state_d  = StIdle;
            end
`ifdef MEM_TIMEOUT_EN
            StErr: begin
                state_d = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            dataMemOut <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= exmem_memwrite;
                mem_addr  <= exmem_addr;
                mem_wdata <= exmem_wdata;
            end
            if (ack_take) begin
                mem_req <= 1'b0;
                // Only a load updates the result; stores leave it untouched.
                if (!mem_we) begin
                    dataMemOut <= mem_rdata;
                end
            end else if (timeout) begin
                mem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          exmem_valid, exmem_memread, exmem_memwrite;
    logic [AW-1:0] exmem_addr;
    logic [DW-1:0] exmem_wdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] dataMemOut;
    logic          wr_MEMWB, MEMWBclear, stall, mem_err;

    int            n_checks = 0;
    int            n_fails  = 0;
    logic [DW-1:0] model_dout;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .exmem_valid   (exmem_valid),
        .exmem_memread (exmem_memread),
        .exmem_memwrite(exmem_memwrite),
        .exmem_addr    (exmem_addr),
        .exmem_wdata   (exmem_wdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .dataMemOut    (dataMemOut),
        .wr_MEMWB      (wr_MEMWB),
        .MEMWBclear    (MEMWBclear),
        .stall         (stall),
        .mem_err       (mem_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // A cycle where no memory op is presented; stray acks must be ignored.
    task automatic idle_cycle(input bit valid);
        @(negedge clk);
        exmem_valid    = valid;
        exmem_memread  = valid ? 1'b0 : 1'($urandom);
        exmem_memwrite = valid ? 1'b0 : 1'($urandom);
        exmem_addr     = AW'($urandom);
        exmem_wdata    = DW'($urandom);
        mem_ack        = 1'($urandom);
        mem_rdata      = DW'($urandom);
        #1;
        check_eq("nomem_wr", wr_MEMWB, 1);
        check_eq("nomem_stall", stall, 0);
        check_eq("nomem_req", mem_req, 0);
        check_eq("nomem_err", mem_err, 0);
        check_eq("nomem_clr", MEMWBclear, 0);
        check_eq("nomem_dout", dataMemOut, model_dout);
    endtask

    // One memory op. lat = number of ACCESS cycles before the ack; a negative value means no ack.
    task automatic run_op(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input int lat);
        bit acked = 0;
        @(negedge clk);
        exmem_valid    = 1'b1;
        exmem_memread  = rd;
        exmem_memwrite = wr;
        exmem_addr     = addr;
        exmem_wdata    = wdata;
        mem_ack        = 1'($urandom);
        mem_rdata      = DW'($urandom);
        #1;
        check_eq("detect_stall", stall, 1);
        check_eq("detect_wr", wr_MEMWB, 0);
        check_eq("detect_req", mem_req, 0);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            mem_ack   = (k == lat);
            mem_rdata = (k == lat) ? rdata : DW'($urandom);
            #1;
            check_eq("acc_req", mem_req, 1);
            check_eq("acc_we", mem_we, wr);
            check_eq("acc_addr", mem_addr, addr);
            check_eq("acc_wdata", mem_wdata, wdata);
            check_eq("acc_stall", stall, 1);
            check_eq("acc_wr", wr_MEMWB, 0);
            check_eq("acc_err", mem_err, 0);
            if (k == lat) begin
                acked = 1;
                break;
            end
`ifdef MEM_TIMEOUT_EN
            if (k == int'(TO) - 1) break;
`endif
        end
        if (acked && !wr) model_dout = rdata;
        @(negedge clk);
        mem_ack   = 1'($urandom);
        mem_rdata = DW'($urandom);
        #1;
        check_eq("end_req", mem_req, 0);
        check_eq("end_dout", dataMemOut, model_dout);
        if (acked) begin
            check_eq("done_stall", stall, 0);
            check_eq("done_wr", wr_MEMWB, 1);
            check_eq("done_err", mem_err, 0);
            check_eq("done_clr", MEMWBclear, 0);
        end else begin
            check_eq("err_stall", stall, 0);
            check_eq("err_wr", wr_MEMWB, 0);
            check_eq("err_err", mem_err, 1);
            check_eq("err_clr", MEMWBclear, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, lat;
        model_dout     = '0;
        reset          = 1'b1;
        exmem_valid    = 1'b0;
        exmem_memread  = 1'b0;
        exmem_memwrite = 1'b0;
        exmem_addr     = '0;
        exmem_wdata    = '0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", mem_req, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_dout", dataMemOut, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_wr", wr_MEMWB, 1);
        check_eq("rst_err", mem_err, 0);
        check_eq("rst_clr", MEMWBclear, 0);
        reset = 1'b0;

        // Non-memory stream, then the directed load and store.
        for (int i = 0; i < 5; i++) idle_cycle(1'b1);
        run_op(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0);
        idle_cycle(1'b0);
        run_op(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h5555, 4);
        // Ack on the last allowed cycle still completes normally.
        run_op(1'b1, 1'b0, 16'h0022, 16'h0000, 16'hA5A5, int'(TO) - 1);
`ifdef MEM_TIMEOUT_EN
        run_op(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0000, -1);
        idle_cycle(1'b1);
`endif

        // Reset during the second ACCESS cycle.
        @(negedge clk);
        exmem_valid    = 1'b1;
        exmem_memread  = 1'b1;
        exmem_memwrite = 1'b1;
        exmem_addr     = 16'h0077;
        exmem_wdata    = 16'h00FF;
        mem_ack        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("mid_req", mem_req, 1);
        @(negedge clk);
        reset       = 1'b0;
        exmem_valid = 1'b0;
        mem_ack     = 1'b1;
        mem_rdata   = 16'hDEAD;
        model_dout  = '0;
        #1;
        check_eq("mrst_req", mem_req, 0);
        check_eq("mrst_we", mem_we, 0);
        check_eq("mrst_addr", mem_addr, 0);
        check_eq("mrst_wdata", mem_wdata, 0);
        check_eq("mrst_dout", dataMemOut, 0);
        check_eq("mrst_stall", stall, 0);
        check_eq("mrst_wr", wr_MEMWB, 1);
        for (int i = 0; i < 3; i++) idle_cycle(1'b0);

        // Random traffic against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 2));
`ifdef MEM_TIMEOUT_EN
            lat = int'($urandom_range(0, TO + 3));
            if (lat >= int'(TO)) lat = -1;
`else
            lat = int'($urandom_range(0, 20));
`endif
            run_op(sel != 1, sel != 0, AW'($urandom), DW'($urandom), DW'($urandom), lat);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) idle_cycle(1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
